// File: rtl/axon_pkg.sv
// Shared definitions for the multi-channel axon stage: packet type codes,
// FSM state encoding and the ceiling-shift helper used for window bounds.
package axon_pkg;

  localparam logic [2:0] PKT_SPIKE    = 3'b000;
  localparam logic [2:0] PKT_DATA     = 3'b001;
  localparam logic [2:0] PKT_DATA_END = 3'b010;
  localparam logic [2:0] PKT_WRITE    = 3'b110;
  localparam logic [2:0] PKT_READ     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_SLIDE = 2'd2,
    ST_INPUT = 2'd3
  } state_e;

  // ceil(v / 2^sh) for signed v; the bias makes the arithmetic shift round up.
  function automatic int ceil_shift(input int v, input int sh);
    return (v + (1 <<< sh) - 1) >>> sh;
  endfunction

endpackage

// File: rtl/axon_fifo.sv
// Small synchronous FIFO holding {type,data} packets in front of the axon FSM.
// Storage is not reset; only pointers and occupancy are.
module axon_fifo #(
  parameter int FDW = 2,
  parameter int PW  = 27
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [PW-1:0] din_i,
  output logic [PW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << FDW;

  logic [PW-1:0]  mem_q [DEPTH];
  logic [FDW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FDW:0]   cnt_q;
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == (FDW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Packet storage write
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + FDW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + FDW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (FDW+1)'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - (FDW+1)'(1);
    end
  end

endmodule

// File: rtl/axon_mc.sv
// Multi-channel axon stage: buffers packets, expands each spike into
// (membrane, weight) address events over all output channels of the clipped
// receptive window, and forwards DATA bursts as sequential soma writes.
// Optional build macro AXON_FC_EN adds fc_mode (fully-connected expansion).
module axon_mc import axon_pkg::*; #(
  parameter int NNW = 12,
  parameter int SW  = 24,
  parameter int FTW = 3,
  parameter int FDW = 2,
  parameter int CW  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           spk_in_vld,
  output logic           spk_in_rdy,
  input  logic [SW-1:0]  spk_in_data,
  input  logic [FTW-1:0] spk_in_type,
  output logic           sd_vld,
  input  logic           sd_rdy,
  output logic [NNW-1:0] sd_vm_addr,
  output logic [NNW-1:0] sd_wgt_addr,
  input  logic [NNW-1:0] x_in,
  input  logic [NNW-1:0] y_in,
  input  logic [NNW-1:0] x_out,
  input  logic [NNW-1:0] y_out,
  input  logic [NNW-1:0] x_k,
  input  logic [NNW-1:0] y_k,
  input  logic [NNW-1:0] pad,
  input  logic [NNW-1:0] stride_log,
  input  logic [CW-1:0]  c_in,
  input  logic [CW-1:0]  c_out,
  output logic           soma_we,
  output logic [NNW-1:0] soma_waddr,
  output logic [SW-1:0]  soma_wdata,
  output logic           busy
`ifdef AXON_FC_EN
  ,input  logic          fc_mode
`endif
);

  localparam int FW = SW / 3;
  localparam int AW = NNW + 2;
  localparam int MW = 32;

  state_e           state_q, state_d;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FTW+SW-1:0] fifo_head;
  logic [FTW-1:0]   head_type;
  logic [SW-1:0]    head_data;

  logic [SW-1:0]    spk_q;
  logic [FW-1:0]    xs_v, ys_v, zs_v;
  int               xs_i, ys_i, zs_i, sl_i, xp_i, yp_i;
  int               xlo_i, xhi_i, ylo_i, yhi_i;
  logic             win_empty, last_evt;

  logic [NNW-1:0]   xout_q, yout_q, xk_q, yk_q;
  logic [CW-1:0]    cin_q, cout_q, co_q;
  logic [1:0]       sl_q;
  logic [AW-1:0]    xp_q, yp_q;
  logic [FW-1:0]    zs_q;
  logic [NNW-1:0]   xlo_q, xhi_q, ylo_q, yhi_q, xo_q, yo_q;
  logic [MW-1:0]    vm_full, wgt_full, xw_full, yw_full;

  logic             soma_we_q;
  logic [NNW-1:0]   soma_waddr_q;
  logic [SW-1:0]    soma_wdata_q;
  logic             unused_bits;

`ifdef AXON_FC_EN
  logic             fc_q;
  logic [MW-1:0]    j_q, n_q, sid_q, sid_c, lim_c, n_c;
`endif

  assign spk_in_rdy = rst_n && !fifo_full;
  assign fifo_push  = spk_in_vld && spk_in_rdy;
  assign fifo_pop   = !fifo_empty && (state_q == ST_IDLE || state_q == ST_INPUT);
  assign head_type  = fifo_head[FTW+SW-1:SW];
  assign head_data  = fifo_head[SW-1:0];

  axon_fifo #(.FDW(FDW), .PW(FTW+SW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({spk_in_type, spk_in_data}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign xs_v = spk_q[FW-1:0];
  assign ys_v = spk_q[2*FW-1:FW];
  assign zs_v = spk_q[SW-1:2*FW];

  // Window bounds of the latched spike against live config (sampled in CALC)
  always_comb begin
    xs_i  = int'(xs_v);
    ys_i  = int'(ys_v);
    zs_i  = int'(zs_v);
    sl_i  = int'(stride_log[1:0]);
    xp_i  = xs_i + int'(pad);
    yp_i  = ys_i + int'(pad);
    xlo_i = ceil_shift(xp_i - int'(x_k) + 1, sl_i);
    ylo_i = ceil_shift(yp_i - int'(y_k) + 1, sl_i);
    if (xlo_i < 0) xlo_i = 0;
    if (ylo_i < 0) ylo_i = 0;
    xhi_i = xp_i >>> sl_i;
    yhi_i = yp_i >>> sl_i;
    if (xhi_i > int'(x_out) - 1) xhi_i = int'(x_out) - 1;
    if (yhi_i > int'(y_out) - 1) yhi_i = int'(y_out) - 1;
    win_empty = (xlo_i > xhi_i) || (ylo_i > yhi_i) || (zs_i >= int'(c_in));
`ifdef AXON_FC_EN
    sid_c = (MW'(zs_v) * MW'(y_in) + MW'(ys_v)) * MW'(x_in) + MW'(xs_v);
    lim_c = MW'(x_in) * MW'(y_in) * MW'(c_in);
    n_c   = MW'(x_out) * MW'(y_out) * MW'(c_out);
    if (fc_mode) win_empty = (sid_c >= lim_c) || (n_c == '0);
`endif
  end

  // Event addresses from the loop counters; wide math, truncated at the port
  always_comb begin
    xw_full  = MW'(xp_q) - (MW'(xo_q) << sl_q);
    yw_full  = MW'(yp_q) - (MW'(yo_q) << sl_q);
    vm_full  = (MW'(co_q) * MW'(yout_q) + MW'(yo_q)) * MW'(xout_q) + MW'(xo_q);
    wgt_full = ((MW'(co_q) * MW'(cin_q) + MW'(zs_q)) * MW'(yk_q) + yw_full) * MW'(xk_q)
               + xw_full;
    last_evt = (xo_q == xhi_q) && (yo_q == yhi_q) && (co_q == cout_q - CW'(1));
`ifdef AXON_FC_EN
    if (fc_q) begin
      vm_full  = j_q;
      wgt_full = sid_q * n_q + j_q;
      last_evt = (j_q == n_q - MW'(1));
    end
`endif
  end

  assign sd_vld      = (state_q == ST_SLIDE);
  assign sd_vm_addr  = sd_vld ? vm_full[NNW-1:0]  : '0;
  assign sd_wgt_addr = sd_vld ? wgt_full[NNW-1:0] : '0;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);
  assign soma_we     = soma_we_q;
  assign soma_waddr  = soma_waddr_q;
  assign soma_wdata  = soma_wdata_q;
  assign unused_bits = ^{x_in, y_in, stride_log[NNW-1:2], vm_full[MW-1:NNW],
                         wgt_full[MW-1:NNW]};

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          case (head_type)
            PKT_SPIKE:                        state_d = ST_CALC;
            PKT_DATA:                         state_d = ST_INPUT;
            PKT_DATA_END, PKT_WRITE, PKT_READ: state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
          endcase
        end
      end
      ST_CALC:  state_d = win_empty ? ST_IDLE : ST_SLIDE;
      ST_SLIDE: if (sd_rdy && last_evt) state_d = ST_IDLE;
      ST_INPUT: if (!fifo_empty && head_type == PKT_DATA_END) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state and soma write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      soma_we_q    <= 1'b0;
      soma_waddr_q <= '0;
      soma_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      soma_we_q <= 1'b0;
      if (fifo_pop && state_q == ST_IDLE && head_type == PKT_DATA) begin
        soma_we_q    <= 1'b1;
        soma_waddr_q <= '0;
        soma_wdata_q <= head_data;
      end else if (fifo_pop && state_q == ST_INPUT &&
                   (head_type == PKT_DATA || head_type == PKT_DATA_END)) begin
        soma_we_q    <= 1'b1;
        soma_waddr_q <= soma_waddr_q + NNW'(1);
        soma_wdata_q <= head_data;
      end
    end
  end

  // Spike latch, config snapshot and window loop counters
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && fifo_pop) spk_q <= head_data;
    if (state_q == ST_CALC) begin
      xout_q <= x_out;
      yout_q <= y_out;
      xk_q   <= x_k;
      yk_q   <= y_k;
      cin_q  <= c_in;
      cout_q <= c_out;
      sl_q   <= stride_log[1:0];
      xp_q   <= AW'(xp_i);
      yp_q   <= AW'(yp_i);
      zs_q   <= zs_v;
      xlo_q  <= NNW'(xlo_i);
      xhi_q  <= NNW'(xhi_i);
      ylo_q  <= NNW'(ylo_i);
      yhi_q  <= NNW'(yhi_i);
      co_q   <= '0;
      xo_q   <= NNW'(xlo_i);
      yo_q   <= NNW'(ylo_i);
`ifdef AXON_FC_EN
      fc_q   <= fc_mode;
      j_q    <= '0;
      n_q    <= n_c;
      sid_q  <= sid_c;
`endif
    end else if (state_q == ST_SLIDE && sd_rdy) begin
`ifdef AXON_FC_EN
      j_q <= j_q + MW'(1);
`endif
      if (xo_q == xhi_q) begin
        xo_q <= xlo_q;
        if (yo_q == yhi_q) begin
          yo_q <= ylo_q;
          co_q <= co_q + CW'(1);
        end else begin
          yo_q <= yo_q + NNW'(1);
        end
      end else begin
        xo_q <= xo_q + NNW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axon_mc.sv
// Scoreboard bench for axon_mc: expected sd events and soma writes are
// queued as stimulus is applied and checked as the DUT hands them over.
module tb_axon_mc;

  localparam int NNW = 12;
  localparam int SW  = 24;
  localparam int FTW = 3;
  localparam int CW  = 4;
  localparam logic [2:0] T_SPIKE = 3'b000, T_DATA = 3'b001, T_DEND = 3'b010, T_WRITE = 3'b110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, spk_in_vld, spk_in_rdy, sd_vld, sd_rdy, soma_we, busy;
  logic [SW-1:0]  spk_in_data, soma_wdata;
  logic [FTW-1:0] spk_in_type;
  logic [NNW-1:0] sd_vm_addr, sd_wgt_addr, soma_waddr;
  logic [NNW-1:0] x_in, y_in, x_out, y_out, x_k, y_k, pad, stride_log;
  logic [CW-1:0]  c_in, c_out;

  int vectors = 0;
  int miscompares = 0;
  logic [NNW-1:0] exp_vm[$], exp_wgt[$];
  int             got_vm[$], got_wgt[$];
  logic [NNW-1:0] exp_sa[$];
  logic [SW-1:0]  exp_sd[$];
  int             soma_seen = 0;

  axon_mc dut (
    .clk(clk), .rst_n(rst_n), .spk_in_vld(spk_in_vld), .spk_in_rdy(spk_in_rdy),
    .spk_in_data(spk_in_data), .spk_in_type(spk_in_type), .sd_vld(sd_vld),
    .sd_rdy(sd_rdy), .sd_vm_addr(sd_vm_addr), .sd_wgt_addr(sd_wgt_addr),
    .x_in(x_in), .y_in(y_in), .x_out(x_out), .y_out(y_out), .x_k(x_k), .y_k(y_k),
    .pad(pad), .stride_log(stride_log), .c_in(c_in), .c_out(c_out),
    .soma_we(soma_we), .soma_waddr(soma_waddr), .soma_wdata(soma_wdata), .busy(busy)
  );

  // Output monitor: sample on the falling edge, pop and compare
  always @(negedge clk) begin : mon
    logic [NNW-1:0] e_vm, e_wgt, e_sa;
    logic [SW-1:0]  e_sd;
    if (rst_n && sd_vld && sd_rdy) begin
      got_vm.push_back(int'(sd_vm_addr));
      got_wgt.push_back(int'(sd_wgt_addr));
      vectors++;
      if (exp_vm.size() == 0) begin
        miscompares++;
        $display("FAIL sd_unexpected: got vm=%0d wgt=%0d, expected no event", sd_vm_addr, sd_wgt_addr);
      end else begin
        e_vm = exp_vm.pop_front();
        e_wgt = exp_wgt.pop_front();
        if (sd_vm_addr !== e_vm || sd_wgt_addr !== e_wgt) begin
          miscompares++;
          $display("FAIL sd_event: got vm=%0d wgt=%0d, expected vm=%0d wgt=%0d",
                   sd_vm_addr, sd_wgt_addr, e_vm, e_wgt);
        end
      end
    end
    if (rst_n && soma_we) begin
      soma_seen++;
      vectors++;
      if (exp_sa.size() == 0) begin
        miscompares++;
        $display("FAIL soma_unexpected: got addr=%0d data=%h", soma_waddr, soma_wdata);
      end else begin
        e_sa = exp_sa.pop_front();
        e_sd = exp_sd.pop_front();
        if (soma_waddr !== e_sa || soma_wdata !== e_sd) begin
          miscompares++;
          $display("FAIL soma_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   soma_waddr, soma_wdata, e_sa, e_sd);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference expansion: scan every output position, keep those whose kernel tap lands in range
  task automatic model_spike(input int xs, input int ys, input int zs);
    int s, xp, yp, xw, yw;
    s  = 1 << int'(stride_log[1:0]);
    xp = xs + int'(pad);
    yp = ys + int'(pad);
    if (zs >= int'(c_in)) return;
    for (int co = 0; co < int'(c_out); co++)
      for (int yo = 0; yo < int'(y_out); yo++)
        for (int xo = 0; xo < int'(x_out); xo++) begin
          xw = xp - xo * s;
          yw = yp - yo * s;
          if (xw >= 0 && xw < int'(x_k) && yw >= 0 && yw < int'(y_k)) begin
            exp_vm.push_back(NNW'((co * int'(y_out) + yo) * int'(x_out) + xo));
            exp_wgt.push_back(NNW'(((co * int'(c_in) + zs) * int'(y_k) + yw) * int'(x_k) + xw));
          end
        end
  endtask

  task automatic send(input logic [2:0] t, input logic [SW-1:0] d);
    int n = 0;
    spk_in_type = t;
    spk_in_data = d;
    spk_in_vld  = 1'b1;
    while (!spk_in_rdy && n < 100) begin tick(); n++; end
    if (!spk_in_rdy) begin
      miscompares++;
      $display("FAIL send_timeout: spk_in_rdy=%b, expected 1 within 100 cycles", spk_in_rdy);
    end
    tick();
    spk_in_vld = 1'b0;
  endtask

  task automatic send_spike(input int xs, input int ys, input int zs);
    model_spike(xs, ys, zs);
    send(T_SPIKE, {8'(zs), 8'(ys), 8'(xs)});
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((exp_vm.size() != 0 || exp_sa.size() != 0 || busy) && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: pending events=%0d writes=%0d busy=%b, expected drained",
               name, exp_vm.size(), exp_sa.size(), busy);
    end
    tick();
  endtask

  task automatic cfg_centre();
    x_in = 4; y_in = 4; x_out = 4; y_out = 4; x_k = 3; y_k = 3;
    pad = 1; stride_log = 0; c_in = 1; c_out = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spk_in_vld = 1'b0; sd_rdy = 1'b1;
    spk_in_type = '0; spk_in_data = '0;
    cfg_centre();
    repeat (3) tick();
    vectors++; if (spk_in_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_rdy: got %b, expected 0", spk_in_rdy); end
    vectors++; if (sd_vld !== 1'b0) begin miscompares++; $display("FAIL rst_sd_vld: got %b, expected 0", sd_vld); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    vectors++; if (soma_we !== 1'b0 || soma_waddr !== '0 || soma_wdata !== '0) begin
      miscompares++; $display("FAIL rst_soma: got we=%b addr=%0d data=%h, expected 0/0/0", soma_we, soma_waddr, soma_wdata); end
    vectors++; if (sd_vm_addr !== '0 || sd_wgt_addr !== '0) begin
      miscompares++; $display("FAIL rst_sd_addr: got vm=%0d wgt=%0d, expected 0/0", sd_vm_addr, sd_wgt_addr); end
    rst_n = 1'b1;
    tick();
    vectors++; if (spk_in_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_release_rdy: got %b, expected 1", spk_in_rdy); end
  endtask

  task automatic test_centre();
    int base, lat;
    cfg_centre();
    base = got_vm.size();
    model_spike(1, 1, 0);
    spk_in_type = T_SPIKE; spk_in_data = {8'd0, 8'd1, 8'd1}; spk_in_vld = 1'b1;
    tick();
    spk_in_vld = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (sd_vld) lat = i;
    end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL centre_latency: got %0d, expected 3", lat); end
    wait_done(200, "centre");
    vectors++; if (got_vm.size() - base !== 9) begin miscompares++; $display("FAIL centre_count: got %0d, expected 9", got_vm.size() - base); end
    if (got_vm.size() - base >= 9) begin
      vectors++; if (got_vm[base] !== 0 || got_wgt[base] !== 8) begin
        miscompares++; $display("FAIL centre_first: got vm=%0d wgt=%0d, expected 0/8", got_vm[base], got_wgt[base]); end
      vectors++; if (got_vm[base+8] !== 10 || got_wgt[base+8] !== 0) begin
        miscompares++; $display("FAIL centre_last: got vm=%0d wgt=%0d, expected 10/0", got_vm[base+8], got_wgt[base+8]); end
    end
  endtask

  task automatic test_corner();
    int base;
    int want[4] = '{0, 1, 4, 5};
    cfg_centre();
    base = got_vm.size();
    send_spike(0, 0, 0);
    wait_done(200, "corner");
    vectors++; if (got_vm.size() - base !== 4) begin miscompares++; $display("FAIL corner_count: got %0d, expected 4", got_vm.size() - base); end
    if (got_vm.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        vectors++; if (got_vm[base+i] !== want[i]) begin
          miscompares++; $display("FAIL corner_vm%0d: got %0d, expected %0d", i, got_vm[base+i], want[i]); end
      end
      vectors++; if (got_wgt[base] !== 4) begin miscompares++; $display("FAIL corner_wgt: got %0d, expected 4", got_wgt[base]); end
    end
  endtask

  task automatic test_empty_window();
    int base;
    cfg_centre();
    x_k = 1; y_k = 1; stride_log = 1; x_out = 2; y_out = 2; pad = 0;
    base = got_vm.size();
    send_spike(1, 0, 0);
    repeat (10) tick();
    vectors++; if (got_vm.size() !== base) begin miscompares++; $display("FAIL empty_events: got %0d, expected 0", got_vm.size() - base); end
    vectors++; if (busy !== 1'b0 || sd_vld !== 1'b0) begin miscompares++; $display("FAIL empty_idle: got busy=%b vld=%b, expected 0/0", busy, sd_vld); end
    send_spike(0, 0, 0);
    send_spike(2, 2, 0);
    wait_done(200, "stride");
    vectors++; if (got_vm.size() - base !== 2) begin miscompares++; $display("FAIL stride_count: got %0d, expected 2", got_vm.size() - base); end
    if (got_vm.size() - base >= 2) begin
      vectors++; if (got_vm[base] !== 0 || got_vm[base+1] !== 3) begin
        miscompares++; $display("FAIL stride_vm: got %0d,%0d, expected 0,3", got_vm[base], got_vm[base+1]); end
    end
  endtask

  task automatic test_channels();
    int base;
    cfg_centre();
    c_out = 2;
    base = got_vm.size();
    send_spike(1, 1, 0);
    wait_done(300, "cout2");
    vectors++; if (got_vm.size() - base !== 18) begin miscompares++; $display("FAIL cout2_count: got %0d, expected 18", got_vm.size() - base); end
    if (got_vm.size() - base >= 18) begin
      vectors++; if (got_vm[base+9] !== 16 || got_wgt[base+9] !== 17) begin
        miscompares++; $display("FAIL cout2_ev10: got vm=%0d wgt=%0d, expected 16/17", got_vm[base+9], got_wgt[base+9]); end
    end
    c_in = 2;
    send_spike(1, 1, 1);
    wait_done(300, "cin2");
    c_in = 1;
    base = got_vm.size();
    send_spike(1, 1, 1);
    repeat (8) tick();
    vectors++; if (got_vm.size() !== base || busy !== 1'b0) begin
      miscompares++; $display("FAIL zs_drop: got events=%0d busy=%b, expected 0/0", got_vm.size() - base, busy); end
  endtask

  task automatic test_backpressure();
    int base, n, accepted, total;
    logic [NNW-1:0] hold_vm, hold_wgt;
    int sx[6] = '{0, 3, 2, 1, 3, 0};
    int sy[6] = '{0, 3, 1, 2, 0, 3};
    cfg_centre();
    base = got_vm.size();
    total = exp_vm.size();
    send_spike(1, 1, 0);
    total = exp_vm.size() - total;
    n = 0;
    while (got_vm.size() - base < 3 && n < 100) begin tick(); n++; end
    vectors++; if (got_vm.size() - base < 3) begin miscompares++; $display("FAIL bp_start: got %0d events, expected 3", got_vm.size() - base); end
    sd_rdy = 1'b0;
    hold_vm = sd_vm_addr;
    hold_wgt = sd_wgt_addr;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      spk_in_type = T_SPIKE; spk_in_data = {8'd0, 8'(sy[i]), 8'(sx[i])}; spk_in_vld = 1'b1;
      vectors++; if (spk_in_rdy !== (accepted < 4)) begin
        miscompares++; $display("FAIL bp_rdy%0d: got %b, expected %b", i, spk_in_rdy, accepted < 4); end
      if (spk_in_rdy) begin
        n = exp_vm.size();
        model_spike(sx[i], sy[i], 0);
        total += exp_vm.size() - n;
        accepted++;
      end
      tick();
      vectors++; if (sd_vld !== 1'b1 || sd_vm_addr !== hold_vm || sd_wgt_addr !== hold_wgt) begin
        miscompares++; $display("FAIL bp_hold%0d: got vld=%b vm=%0d wgt=%0d, expected 1/%0d/%0d",
                                i, sd_vld, sd_vm_addr, sd_wgt_addr, hold_vm, hold_wgt); end
    end
    spk_in_vld = 1'b0;
    vectors++; if (accepted !== 4) begin miscompares++; $display("FAIL bp_accepted: got %0d, expected 4", accepted); end
    sd_rdy = 1'b1;
    wait_done(800, "bp");
    vectors++; if (got_vm.size() - base !== total) begin
      miscompares++; $display("FAIL bp_total: got %0d, expected %0d", got_vm.size() - base, total); end
  endtask

  task automatic test_data_burst();
    int base;
    base = soma_seen;
    send(T_DEND, 24'h0BAD00);
    repeat (3) tick();
    vectors++; if (soma_seen !== base) begin miscompares++; $display("FAIL stray_dend: got %0d writes, expected 0", soma_seen - base); end
    exp_sa.push_back(0); exp_sd.push_back(24'hA1A2A3);
    exp_sa.push_back(1); exp_sd.push_back(24'hB1B2B3);
    exp_sa.push_back(2); exp_sd.push_back(24'hC1C2C3);
    send(T_DATA, 24'hA1A2A3);
    send(T_WRITE, 24'h777777);
    send(T_DATA, 24'hB1B2B3);
    send(T_DEND, 24'hC1C2C3);
    wait_done(100, "burst");
    repeat (2) tick();
    vectors++; if (soma_seen - base !== 3) begin miscompares++; $display("FAIL burst_count: got %0d, expected 3", soma_seen - base); end
    vectors++; if (soma_we !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL burst_after: got we=%b busy=%b, expected 0/0", soma_we, busy); end
  endtask

  task automatic test_reset_mid_slide();
    int base, n;
    cfg_centre();
    base = got_vm.size();
    send_spike(1, 1, 0);
    send(T_SPIKE, {8'd0, 8'd2, 8'd2});
    n = 0;
    while (got_vm.size() - base < 3 && n < 100) begin tick(); n++; end
    vectors++; if (sd_vld !== 1'b1) begin miscompares++; $display("FAIL mid_active: got vld=%b, expected 1", sd_vld); end
    rst_n = 1'b0;
    tick();
    vectors++; if (sd_vld !== 1'b0 || busy !== 1'b0 || spk_in_rdy !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: got vld=%b busy=%b rdy=%b, expected 0/0/0", sd_vld, busy, spk_in_rdy); end
    exp_vm.delete();
    exp_wgt.delete();
    rst_n = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0 || spk_in_rdy !== 1'b1) begin
      miscompares++; $display("FAIL mid_release: got busy=%b rdy=%b, expected 0/1", busy, spk_in_rdy); end
    base = got_vm.size();
    send_spike(1, 1, 0);
    wait_done(200, "fresh");
    vectors++; if (got_vm.size() - base !== 9) begin miscompares++; $display("FAIL fresh_count: got %0d, expected 9", got_vm.size() - base); end
    if (got_vm.size() - base >= 1) begin
      vectors++; if (got_vm[base] !== 0 || got_wgt[base] !== 8) begin
        miscompares++; $display("FAIL fresh_first: got vm=%0d wgt=%0d, expected 0/8", got_vm[base], got_wgt[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_centre();
    test_corner();
    test_empty_window();
    test_channels();
    test_backpressure();
    test_data_burst();
    test_reset_mid_slide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
